// File: rtl/reg_bus_arbiter_if.sv
// Master-side register bus port for reg_bus_arbiter.
// One instance per master: level req, one ack per transaction.
interface reg_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [1:0]    be;
  logic [DW-1:0] wrdata;
  logic          ack;
  logic [DW-1:0] rddata;

  modport master (
    output req, we, addr, be, wrdata,
    input  ack, rddata
  );

  modport slave (
    input  req, we, addr, be, wrdata,
    output ack, rddata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the shared 16-bit register bus.
// Round-robin; define REG_BUS_ARB_FIXED_PRIO_EN for fixed m0 priority.
module reg_bus_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic          sclr,
  reg_bus_arbiter_if.slave m0,
  reg_bus_arbiter_if.slave m1,
  output logic [AW-1:0] rdaddr,
  output logic [AW-1:0] wraddr,
  output logic [1:0]    be,
  output logic          write,
  output logic [DW-1:0] wrdata,
  input  logic [DW-1:0] rddata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdat0_q;
  logic [DW-1:0] rdat1_q;

  logic          any_req;
  logic          pick_m1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_be;
  logic [DW-1:0] sel_wd;

`ifndef REG_BUS_ARB_FIXED_PRIO_EN
  // 1 = m1 owned the most recent grant
  logic last_m1;
`endif

  assign any_req = m0.req | m1.req;

  // Pick the winner among pending requests
  always_comb begin
    pick_m1 = 1'b0;
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    pick_m1 = m1.req & ~m0.req;
`else
    if (m0.req && m1.req)
      pick_m1 = ~last_m1;
    else
      pick_m1 = m1.req;
`endif
  end

  assign sel_we   = pick_m1 ? m1.we     : m0.we;
  assign sel_addr = pick_m1 ? m1.addr   : m0.addr;
  assign sel_be   = pick_m1 ? m1.be     : m0.be;
  assign sel_wd   = pick_m1 ? m1.wrdata : m0.wrdata;

  assign m0.ack    = ack0_q;
  assign m1.ack    = ack1_q;
  assign m0.rddata = rdat0_q;
  assign m1.rddata = rdat1_q;

  // Transaction FSM with registered bus and ack outputs
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdaddr  <= '0;
      wraddr  <= '0;
      be      <= '0;
      write   <= 1'b0;
      wrdata  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
      grant   <= '0;
      busy    <= 1'b0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
      last_m1 <= 1'b1;
`endif
    end else if (sclr) begin
      state   <= IDLE;
      cnt     <= '0;
      write   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant   <= '0;
      busy    <= 1'b0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
      last_m1 <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick_m1 ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            cnt   <= '0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
            last_m1 <= pick_m1;
`endif
            if (sel_we) begin
              state  <= WR;
              wraddr <= sel_addr;
              be     <= sel_be;
              wrdata <= sel_wd;
              write  <= 1'b1;
              ack0_q <= ~pick_m1;
              ack1_q <= pick_m1;
            end else begin
              state  <= RD;
              rdaddr <= sel_addr;
            end
          end
        end
        WR: begin
          write  <= 1'b0;
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          grant  <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (grant[1]) begin
              rdat1_q <= rddata;
              ack1_q  <= 1'b1;
            end else begin
              rdat0_q <= rddata;
              ack0_q  <= 1'b1;
            end
            state <= RACK;
          end
        end
        RACK: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          grant  <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter.
// Expected acks are queued at issue; a negedge monitor pops them.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        sclr;
  logic [15:0] rdaddr;
  logic [15:0] wraddr;
  logic [1:0]  be;
  logic        write;
  logic [15:0] wrdata;
  logic [15:0] rddata;
  logic [1:0]  grant;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  reg_bus_arbiter_if #(.AW(16), .DW(16)) m0i ();
  reg_bus_arbiter_if #(.AW(16), .DW(16)) m1i ();

  reg_bus_arbiter #(
    .AW(16),
    .DW(16),
    .RD_LAT(2)
  ) dut (
    .clk(clk),
    .aclr_n(aclr_n),
    .sclr(sclr),
    .m0(m0i),
    .m1(m1i),
    .rdaddr(rdaddr),
    .wraddr(wraddr),
    .be(be),
    .write(write),
    .wrdata(wrdata),
    .rddata(rddata),
    .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fab(logic [15:0] a);
    return (a == 16'h01C4) ? 16'h1234 : ~a;
  endfunction

  // Fabric: data for rdaddr appears one edge later (RD_LAT=2 total)
  always @(posedge clk) rddata <= fab(rdaddr);

  typedef struct {
    int          m;
    bit          we;
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int m, input bit we, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] b);
    exp_t e;
    e.m = m; e.we = we; e.a = a; e.d = d; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int m, input bit r, input bit w,
                       input logic [15:0] a, input logic [1:0] b,
                       input logic [15:0] d);
    if (m == 0) begin
      m0i.req = r; m0i.we = w; m0i.addr = a;
      m0i.be = b; m0i.wrdata = d;
    end else begin
      m1i.req = r; m1i.we = w; m1i.addr = a;
      m1i.be = b; m1i.wrdata = d;
    end
  endtask

  function automatic bit ackof(input int m);
    return (m == 0) ? m0i.ack : m1i.ack;
  endfunction

  // Hold req level for n transactions, stepping addr/data after each ack
  task automatic run(input int m, input int n, input bit we,
                     input logic [15:0] a [4], input logic [15:0] d [4],
                     input logic [1:0] b [4], output int t [4]);
    int k;
    @(negedge clk);
    drive(m, 1'b1, we, a[0], b[0], d[0]);
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!ackof(m) && k < 100);
      if (!ackof(m)) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_timeout m%0d txn %0d: got no ack, required ack", m, i);
      end
      t[i] = cyc;
      if (i + 1 < n)
        drive(m, 1'b1, we, a[i+1], b[i+1], d[i+1]);
      else
        drive(m, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    end
  endtask

  // Monitor: every ack must match the head of the expected queue
  always @(negedge clk) begin : mon
    int   m;
    exp_t e;
    if (aclr_n && write && !(m0i.ack || m1i.ack))
      chk("write_has_ack", 32'(m0i.ack | m1i.ack), 32'd1);
    if (aclr_n && (m0i.ack || m1i.ack)) begin
      m = m1i.ack ? 1 : 0;
      chk("single_ack", 32'(m0i.ack & m1i.ack), 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack on m%0d, required none", m);
      end else begin
        e = exp_q.pop_front();
        chk("ack_owner", 32'(m), 32'(e.m));
        chk("ack_grant", 32'(grant), 32'(1 << e.m));
        if (e.we) begin
          chk("wr_strobe", 32'(write), 32'd1);
          chk("wr_addr", 32'(wraddr), 32'(e.a));
          chk("wr_data", 32'(wrdata), 32'(e.d));
          chk("wr_be", 32'(be), 32'(e.b));
        end else begin
          chk("rd_data", 32'(m ? m1i.rddata : m0i.rddata), 32'(e.d));
          chk("rd_no_wr", 32'(write), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t [4];
    aclr_n = 1'b0;
    sclr   = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    repeat (3) @(negedge clk);

    chk("rst_rdaddr", 32'(rdaddr), 32'h0);
    chk("rst_wraddr", 32'(wraddr), 32'h0);
    chk("rst_be", 32'(be), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_wrdata", 32'(wrdata), 32'h0);
    chk("rst_acks", 32'({m0i.ack, m1i.ack}), 32'h0);
    chk("rst_rd0", 32'(m0i.rddata), 32'h0);
    chk("rst_rd1", 32'(m1i.rddata), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    aclr_n = 1'b1;

    // m0 single write
    @(negedge clk);
    push(0, 1'b1, 16'h0182, 16'hA5A5, 2'b11);
    drive(0, 1'b1, 1'b1, 16'h0182, 2'b11, 16'hA5A5);
    @(negedge clk);
    chk("t1_write", 32'(write), 32'd1);
    chk("t1_wraddr", 32'(wraddr), 32'h0182);
    chk("t1_wrdata", 32'(wrdata), 32'hA5A5);
    chk("t1_ack", 32'(m0i.ack), 32'd1);
    drive(0, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    @(negedge clk);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_write_done", 32'(write), 32'd0);

    // m1 single read with latency checks
    @(negedge clk);
    push(1, 1'b0, 16'h01C4, 16'h1234, 2'b00);
    drive(1, 1'b1, 1'b0, 16'h01C4, 2'b00, 16'h0);
    @(negedge clk);
    chk("t2_rdaddr1", 32'(rdaddr), 32'h01C4);
    chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_noack1", 32'(m1i.ack), 32'd0);
    @(negedge clk);
    chk("t2_rdaddr2", 32'(rdaddr), 32'h01C4);
    chk("t2_noack2", 32'(m1i.ack), 32'd0);
    @(negedge clk);
    chk("t2_ack", 32'(m1i.ack), 32'd1);
    chk("t2_data", 32'(m1i.rddata), 32'h1234);
    drive(1, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);

    // Both masters reading continuously
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    push(0, 1'b0, 16'h0200, 16'hFDFF, 2'b00);
    push(0, 1'b0, 16'h0210, 16'hFDEF, 2'b00);
    push(1, 1'b0, 16'h0300, 16'hFCFF, 2'b00);
    push(1, 1'b0, 16'h0310, 16'hFCEF, 2'b00);
`else
    push(0, 1'b0, 16'h0200, 16'hFDFF, 2'b00);
    push(1, 1'b0, 16'h0300, 16'hFCFF, 2'b00);
    push(0, 1'b0, 16'h0210, 16'hFDEF, 2'b00);
    push(1, 1'b0, 16'h0310, 16'hFCEF, 2'b00);
`endif
    fork
      begin
        int t0 [4];
        run(0, 2, 1'b0, '{16'h0200, 16'h0210, 16'h0, 16'h0},
            '{16'h0, 16'h0, 16'h0, 16'h0}, '{2'b0, 2'b0, 2'b0, 2'b0}, t0);
      end
      begin
        int t1 [4];
        run(1, 2, 1'b0, '{16'h0300, 16'h0310, 16'h0, 16'h0},
            '{16'h0, 16'h0, 16'h0, 16'h0}, '{2'b0, 2'b0, 2'b0, 2'b0}, t1);
      end
    join

    // m0 three back-to-back writes
    push(0, 1'b1, 16'h0100, 16'h1001, 2'b11);
    push(0, 1'b1, 16'h0102, 16'h2002, 2'b01);
    push(0, 1'b1, 16'h0104, 16'h3003, 2'b10);
    run(0, 3, 1'b1, '{16'h0100, 16'h0102, 16'h0104, 16'h0},
        '{16'h1001, 16'h2002, 16'h3003, 16'h0},
        '{2'b11, 2'b01, 2'b10, 2'b00}, t);
    chk("t4_gap01", 32'(t[1] - t[0]), 32'd2);
    chk("t4_gap12", 32'(t[2] - t[1]), 32'd2);

    // sclr in second RD cycle aborts the read
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0400, 2'b00, 16'h0);
    @(negedge clk);
    @(negedge clk);
    sclr = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    @(negedge clk);
    sclr = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_noack", 32'(m0i.ack), 32'd0);
    chk("t5_rd0_kept", 32'(m0i.rddata), 32'hFDEF);
    push(0, 1'b1, 16'h0600, 16'hAAAA, 2'b11);
    push(1, 1'b1, 16'h0700, 16'hBBBB, 2'b11);
    fork
      begin
        int t0 [4];
        run(0, 1, 1'b1, '{16'h0600, 16'h0, 16'h0, 16'h0},
            '{16'hAAAA, 16'h0, 16'h0, 16'h0}, '{2'b11, 2'b0, 2'b0, 2'b0}, t0);
      end
      begin
        int t1 [4];
        run(1, 1, 1'b1, '{16'h0700, 16'h0, 16'h0, 16'h0},
            '{16'hBBBB, 16'h0, 16'h0, 16'h0}, '{2'b11, 2'b0, 2'b0, 2'b0}, t1);
      end
    join

    // Async reset in the middle of a write
    @(negedge clk);
    push(0, 1'b1, 16'h0500, 16'h1111, 2'b01);
    drive(0, 1'b1, 1'b1, 16'h0500, 2'b01, 16'h1111);
    @(negedge clk);
    chk("t6_write", 32'(write), 32'd1);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("t6_write_clr", 32'(write), 32'd0);
    chk("t6_wraddr_clr", 32'(wraddr), 32'd0);
    chk("t6_wrdata_clr", 32'(wrdata), 32'd0);
    chk("t6_be_clr", 32'(be), 32'd0);
    chk("t6_rdaddr_clr", 32'(rdaddr), 32'd0);
    chk("t6_ack_clr", 32'({m0i.ack, m1i.ack}), 32'd0);
    chk("t6_grant_clr", 32'(grant), 32'd0);
    chk("t6_busy_clr", 32'(busy), 32'd0);
    chk("t6_rd0_clr", 32'(m0i.rddata), 32'd0);
    chk("t6_rd1_clr", 32'(m1i.rddata), 32'd0);
    drive(0, 1'b0, 1'b0, 16'h0, 2'b0, 16'h0);
    @(negedge clk);
    aclr_n = 1'b1;
    push(1, 1'b0, 16'h01C4, 16'h1234, 2'b00);
    run(1, 1, 1'b0, '{16'h01C4, 16'h0, 16'h0, 16'h0},
        '{16'h0, 16'h0, 16'h0, 16'h0}, '{2'b0, 2'b0, 2'b0, 2'b0}, t);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
